time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Downstream consumer of the UART time-setting receiver's `ore[4:0]`, `minute[5:0]` and `load` outputs.
- Holds the running wall-clock time (hours/minutes/seconds) and advances it from a prescaled system clock.
- Reloads the time when a new setting arrives.
- Derives the "go home" indication and the minutes remaining until the configured home time, for the display/alert stages.

Parameters:
- TICK_DIV, 50000000, clock cycles per second; a bench uses 4.
- HOME_HOUR, 16, go-home hour, 0..23.
- HOME_MIN, 0, go-home minute, 0..59.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ore_in  in  5  hours from the receiver, valid while load is high.
- minute_in  in  6  minutes from the receiver, valid while load is high.
- load  in  1  load request from the receiver, level; only its rising edge acts.
- run_en  in  1  1 = time advances; 0 = time frozen.
- ore  out  5  current hours, 0..23.
- minute  out  6  current minutes, 0..59.
- secunde  out  6  current seconds, 0..59.
- sec_tick  out  1  one-cycle pulse on each accepted second increment.
- valid  out  1  1 once a legal time has been loaded since reset.
- load_err  out  1  one-cycle pulse when a load edge carries an illegal value.
- go_home  out  1  1 when current hh:mm >= HOME_HOUR:HOME_MIN.
- minutes_left  out  11  (HOME total minutes − current total minutes), saturated at 0.

Behaviour:
- Reset (reset=0): all outputs 0, prescaler 0, load edge register 0, valid 0.
- Load edge: `load_q` is a registered copy of `load`; an edge is `load & ~load_q`. Holding `load` high does not reload.
- Accepted load: an edge with `ore_in <= 23` and `minute_in <= 59`. On the next clock:
  - `ore <= ore_in`, `minute <= minute_in`
  - `secunde <= 0`, prescaler <= 0
  - `valid <= 1`
- Rejected load: an edge with `ore_in > 23` or `minute_in > 59`. Time, prescaler and valid are unchanged; `load_err` pulses one cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while `valid & run_en`; otherwise it holds its value.
  - At TICK_DIV-1 it wraps to 0 and generates a tick.
- Second increment on tick:
  - `secunde` increments and `sec_tick` pulses in the same cycle the counters update.
  - 59→0 carries into `minute`; `minute` 59→0 carries into `ore`; `ore` 23→0.
  - 23:59:59 → 00:00:00 in a single cycle.
- Simultaneous accepted load and tick: the load wins, no `sec_tick` is issued, and the prescaler restarts at 0.
- `run_en` falling mid-second: the prescaler value is kept, so the partial second resumes when `run_en` returns to 1.
- Derived outputs `go_home` and `minutes_left`:
  - Registered from the current time registers, so they lag the time by exactly 1 cycle.
  - Both are 0 while `valid = 0`.
  - `total = ore*60 + minute`, computed at 11 bits (max 1439); `home = HOME_HOUR*60 + HOME_MIN`.
  - `go_home = (total >= home)`; `minutes_left = go_home ? 0 : home − total`.
  - `go_home` drops at the midnight wrap when HOME > 00:00.
- Reset asserted mid-second or mid-load: immediate clear. Load edge detection restarts from `load_q = 0`, so a `load` held high through reset release is treated as a new edge.

Optional Feature:
- Macro: `TIME_KEEPER_BCD_EN`.
- Defined: adds outputs `ore_bcd[7:0]` and `minute_bcd[7:0]` (tens in [7:4], units in [3:0]).
  - Registered with the same 1-cycle lag as `go_home`.
  - Reset value 8'h00.
  - Conversion uses compare/subtract on the small ranges; no divider.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, then load edge with 9/30 (TICK_DIV=4, HOME 16:00) → `ore=9`, `minute=30`, `secunde=0`, `valid=1`; one cycle later `minutes_left=390`, `go_home=0`.
- Load 23:59, `run_en=1`, run 60 ticks → exactly 60 `sec_tick` pulses, with the wrap on the 60th tick (cycle 240 after load) giving 00:00:00.
- Load edge with 24/10, then 5/60 → two `load_err` pulses; time stays at the prior value; `valid` unchanged.
- Load 15:59:00, run 60 ticks → on the 60th tick `minute=0`, `ore=16`; next cycle `go_home=1`, `minutes_left=0`.
- `run_en=0` for 20 cycles mid-second, with a prescaler at 2 → counters frozen; after re-enable the tick arrives 2 cycles later.
- Load edge coincident with a prescaler wrap → the loaded value appears with `secunde=0` and no `sec_tick`. Also: `load` held high for 10 cycles → exactly one load; async reset mid-count → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/time_keeper_if.sv
// time_keeper_if: bundles the time-setting inputs and the wall-clock outputs
// of time_keeper. The slave modport is the keeper itself; the master modport
// is whoever drives the setting (receiver or bench).
// Optional outputs ore_bcd/minute_bcd exist only with TIME_KEEPER_BCD_EN.
interface time_keeper_if;
    logic [4:0]  ore_in;
    logic [5:0]  minute_in;
    logic        load;
    logic        run_en;
    logic [4:0]  ore;
    logic [5:0]  minute;
    logic [5:0]  secunde;
    logic        sec_tick;
    logic        valid;
    logic        load_err;
    logic        go_home;
    logic [10:0] minutes_left;
`ifdef TIME_KEEPER_BCD_EN
    logic [7:0]  ore_bcd;
    logic [7:0]  minute_bcd;
`endif

    modport master (
        output ore_in, minute_in, load, run_en,
        input  ore, minute, secunde, sec_tick, valid, load_err, go_home, minutes_left
`ifdef TIME_KEEPER_BCD_EN
        , input ore_bcd, minute_bcd
`endif
    );

    modport slave (
        input  ore_in, minute_in, load, run_en,
        output ore, minute, secunde, sec_tick, valid, load_err, go_home, minutes_left
`ifdef TIME_KEEPER_BCD_EN
        , output ore_bcd, minute_bcd
`endif
    );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: running hh:mm:ss wall clock advanced by a TICK_DIV prescaler,
// reloaded on the rising edge of load with a legal hh:mm, plus registered
// "go home" flag and minutes-left count (1-cycle lag behind the time).
// Optional macro TIME_KEEPER_BCD_EN adds registered BCD hour/minute outputs.
// Load semantics: load is a level; only the cycle where load=1 and the
// registered copy load_q=0 counts as a request. There is no backpressure.
module time_keeper #(
    parameter int TICK_DIV  = 50000000,
    parameter int HOME_HOUR = 16,
    parameter int HOME_MIN  = 0
) (
    input logic          clock,
    input logic          reset,
    time_keeper_if.slave bus
);
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [10:0]     HOME_TOTAL = 11'(HOME_HOUR * 60 + HOME_MIN);

    logic          load_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    ore_q, ore_d;
    logic [5:0]    minute_q, minute_d;
    logic [5:0]    secunde_q, secunde_d;
    logic          sec_tick_q, sec_tick_d;
    logic          valid_q, valid_d;
    logic          load_err_q, load_err_d;
    logic          go_home_q, go_home_d;
    logic [10:0]   minutes_left_q, minutes_left_d;
    logic [10:0]   total;

    logic load_edge, load_legal, run, tick;

    assign load_edge  = bus.load & ~load_q;
    assign load_legal = (bus.ore_in <= 5'd23) && (bus.minute_in <= 6'd59);
    assign run        = valid_q & bus.run_en;
    assign tick       = run && (presc_q == PRESC_MAX);

    // Next time state: an accepted load beats a coincident tick.
    always_comb begin
        presc_d    = presc_q;
        ore_d      = ore_q;
        minute_d   = minute_q;
        secunde_d  = secunde_q;
        valid_d    = valid_q;
        sec_tick_d = 1'b0;
        load_err_d = load_edge & ~load_legal;
        if (load_edge && load_legal) begin
            ore_d     = bus.ore_in;
            minute_d  = bus.minute_in;
            secunde_d = 6'd0;
            presc_d   = '0;
            valid_d   = 1'b1;
        end else if (tick) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            if (secunde_q == 6'd59) begin
                secunde_d = 6'd0;
                if (minute_q == 6'd59) begin
                    minute_d = 6'd0;
                    ore_d    = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
                end else begin
                    minute_d = minute_q + 6'd1;
                end
            end else begin
                secunde_d = secunde_q + 6'd1;
            end
        end else if (run) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Derived outputs from the current (registered) time.
    always_comb begin
        total          = 11'(ore_q) * 11'd60 + 11'(minute_q);
        go_home_d      = valid_q && (total >= HOME_TOTAL);
        minutes_left_d = (valid_q && !go_home_d) ? (HOME_TOTAL - total) : 11'd0;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_q         <= 1'b0;
            presc_q        <= '0;
            ore_q          <= 5'd0;
            minute_q       <= 6'd0;
            secunde_q      <= 6'd0;
            sec_tick_q     <= 1'b0;
            valid_q        <= 1'b0;
            load_err_q     <= 1'b0;
            go_home_q      <= 1'b0;
            minutes_left_q <= 11'd0;
        end else begin
            load_q         <= bus.load;
            presc_q        <= presc_d;
            ore_q          <= ore_d;
            minute_q       <= minute_d;
            secunde_q      <= secunde_d;
            sec_tick_q     <= sec_tick_d;
            valid_q        <= valid_d;
            load_err_q     <= load_err_d;
            go_home_q      <= go_home_d;
            minutes_left_q <= minutes_left_d;
        end
    end

    assign bus.ore          = ore_q;
    assign bus.minute       = minute_q;
    assign bus.secunde      = secunde_q;
    assign bus.sec_tick     = sec_tick_q;
    assign bus.valid        = valid_q;
    assign bus.load_err     = load_err_q;
    assign bus.go_home      = go_home_q;
    assign bus.minutes_left = minutes_left_q;

`ifdef TIME_KEEPER_BCD_EN
    logic [7:0] ore_bcd_q, minute_bcd_q;

    // Binary 0..59 to two BCD digits by successive compare/subtract.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
        if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
        if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
        return {t, 4'(r)};
    endfunction

    // BCD copies of the time, same 1-cycle lag as go_home.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ore_bcd_q    <= 8'h00;
            minute_bcd_q <= 8'h00;
        end else begin
            ore_bcd_q    <= to_bcd({1'b0, ore_q});
            minute_bcd_q <= to_bcd(minute_q);
        end
    end

    assign bus.ore_bcd    = ore_bcd_q;
    assign bus.minute_bcd = minute_bcd_q;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed table-driven load vectors plus hand-written
// multi-cycle sequences for time_keeper with TICK_DIV=4, home 16:00.
module tb_time_keeper;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    time_keeper_if tk_if();

    time_keeper #(.TICK_DIV(4), .HOME_HOUR(16), .HOME_MIN(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tk_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [4:0]  eh;
        logic [5:0]  em;
        logic        ev;
        logic        eerr;
        logic [10:0] eleft;
        logic        ego;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One-cycle load pulse; returns just after the accepting edge.
    task automatic drive_load(input logic [4:0] h, input logic [5:0] m);
        tk_if.ore_in    = h;
        tk_if.minute_in = m;
        tk_if.load      = 1'b1;
        cyc(1);
        tk_if.load      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ore"},      32'(tk_if.ore), 0);
        chk({tag, "_minute"},   32'(tk_if.minute), 0);
        chk({tag, "_secunde"},  32'(tk_if.secunde), 0);
        chk({tag, "_sec_tick"}, 32'(tk_if.sec_tick), 0);
        chk({tag, "_valid"},    32'(tk_if.valid), 0);
        chk({tag, "_load_err"}, 32'(tk_if.load_err), 0);
        chk({tag, "_go_home"},  32'(tk_if.go_home), 0);
        chk({tag, "_left"},     32'(tk_if.minutes_left), 0);
`ifdef TIME_KEEPER_BCD_EN
        chk({tag, "_ore_bcd"},  32'(tk_if.ore_bcd), 0);
        chk({tag, "_min_bcd"},  32'(tk_if.minute_bcd), 0);
`endif
    endtask

    initial begin
        int cnt;
        // {h, m, exp h, exp m, exp valid, exp err, exp minutes_left, exp go_home}
        vecs[0] = '{5'd25, 6'd0,  5'd0,  6'd0,  1'b0, 1'b1, 11'd0,   1'b0};
        vecs[1] = '{5'd9,  6'd30, 5'd9,  6'd30, 1'b1, 1'b0, 11'd390, 1'b0};
        vecs[2] = '{5'd24, 6'd10, 5'd9,  6'd30, 1'b1, 1'b1, 11'd390, 1'b0};
        vecs[3] = '{5'd5,  6'd60, 5'd9,  6'd30, 1'b1, 1'b1, 11'd390, 1'b0};
        vecs[4] = '{5'd16, 6'd0,  5'd16, 6'd0,  1'b1, 1'b0, 11'd0,   1'b1};
        vecs[5] = '{5'd0,  6'd0,  5'd0,  6'd0,  1'b1, 1'b0, 11'd960, 1'b0};
        vecs[6] = '{5'd23, 6'd59, 5'd23, 6'd59, 1'b1, 1'b0, 11'd0,   1'b1};
        vecs[7] = '{5'd15, 6'd59, 5'd15, 6'd59, 1'b1, 1'b0, 11'd1,   1'b0};
        vecs[8] = '{5'd31, 6'd63, 5'd15, 6'd59, 1'b1, 1'b1, 11'd1,   1'b0};

        // Clock/reset
        reset           = 1'b0;
        tk_if.ore_in    = '0;
        tk_if.minute_in = '0;
        tk_if.load      = 1'b0;
        tk_if.run_en    = 1'b0;
        cyc(3);
        check_all_zero("reset");
        reset = 1'b1;
        cyc(2);

        // Table-driven load vectors, time frozen.
        foreach (vecs[i]) begin
            drive_load(vecs[i].h, vecs[i].m);
            chk($sformatf("v%0d_ore", i),      32'(tk_if.ore), 32'(vecs[i].eh));
            chk($sformatf("v%0d_minute", i),   32'(tk_if.minute), 32'(vecs[i].em));
            chk($sformatf("v%0d_secunde", i),  32'(tk_if.secunde), 0);
            chk($sformatf("v%0d_valid", i),    32'(tk_if.valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_load_err", i), 32'(tk_if.load_err), 32'(vecs[i].eerr));
            cyc(1);
            chk($sformatf("v%0d_err_drop", i), 32'(tk_if.load_err), 0);
            chk($sformatf("v%0d_left", i),     32'(tk_if.minutes_left), 32'(vecs[i].eleft));
            chk($sformatf("v%0d_go_home", i),  32'(tk_if.go_home), 32'(vecs[i].ego));
`ifdef TIME_KEEPER_BCD_EN
            chk($sformatf("v%0d_ore_bcd", i),  32'(tk_if.ore_bcd),
                32'({4'(vecs[i].eh / 10), 4'(vecs[i].eh % 10)}));
            chk($sformatf("v%0d_min_bcd", i),  32'(tk_if.minute_bcd),
                32'({4'(vecs[i].em / 10), 4'(vecs[i].em % 10)}));
`endif
        end

        // Load held high for 10 cycles: only the first cycle loads.
        tk_if.ore_in    = 5'd7;
        tk_if.minute_in = 6'd7;
        tk_if.load      = 1'b1;
        cyc(1);
        chk("hold_first_ore", 32'(tk_if.ore), 7);
        tk_if.ore_in    = 5'd8;
        tk_if.minute_in = 6'd8;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            cnt += int'(tk_if.load_err);
        end
        chk("hold_ore", 32'(tk_if.ore), 7);
        chk("hold_minute", 32'(tk_if.minute), 7);
        chk("hold_no_err", 32'(cnt), 0);
        tk_if.load = 1'b0;
        cyc(1);

        // 23:59:00 for 60 ticks: wrap to 00:00:00 on the 60th tick.
        tk_if.run_en = 1'b1;
        drive_load(5'd23, 6'd59);
        chk("wrap_load_sec", 32'(tk_if.secunde), 0);
        cnt = 0;
        for (int i = 1; i <= 240; i++) begin
            cyc(1);
            cnt += int'(tk_if.sec_tick);
            if (i == 239) begin
                chk("wrap_pre_sec", 32'(tk_if.secunde), 59);
                chk("wrap_pre_ore", 32'(tk_if.ore), 23);
            end
        end
        chk("wrap_ticks", 32'(cnt), 60);
        chk("wrap_ore", 32'(tk_if.ore), 0);
        chk("wrap_minute", 32'(tk_if.minute), 0);
        chk("wrap_secunde", 32'(tk_if.secunde), 0);
        chk("wrap_sec_tick", 32'(tk_if.sec_tick), 1);
        chk("wrap_go_lag", 32'(tk_if.go_home), 1);
        tk_if.run_en = 1'b0;
        cyc(1);
        chk("wrap_go_drop", 32'(tk_if.go_home), 0);
        chk("wrap_left", 32'(tk_if.minutes_left), 960);

        // 15:59:00 for 60 ticks reaches 16:00, go_home one cycle later.
        tk_if.run_en = 1'b1;
        drive_load(5'd15, 6'd59);
        for (int i = 1; i <= 240; i++) cyc(1);
        chk("home_ore", 32'(tk_if.ore), 16);
        chk("home_minute", 32'(tk_if.minute), 0);
        chk("home_go_lag", 32'(tk_if.go_home), 0);
        chk("home_left_lag", 32'(tk_if.minutes_left), 1);
        tk_if.run_en = 1'b0;
        cyc(1);
        chk("home_go", 32'(tk_if.go_home), 1);
        chk("home_left", 32'(tk_if.minutes_left), 0);

        // run_en low for 20 cycles with the prescaler at 2.
        tk_if.run_en = 1'b1;
        drive_load(5'd10, 6'd0);
        cyc(2);
        tk_if.run_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            cnt += int'(tk_if.sec_tick);
        end
        chk("freeze_ticks", 32'(cnt), 0);
        chk("freeze_sec", 32'(tk_if.secunde), 0);
        tk_if.run_en = 1'b1;
        cyc(1);
        chk("resume_no_tick", 32'(tk_if.sec_tick), 0);
        cyc(1);
        chk("resume_tick", 32'(tk_if.sec_tick), 1);
        chk("resume_sec", 32'(tk_if.secunde), 1);

        // Load coincident with a prescaler wrap.
        drive_load(5'd10, 6'd0);
        cyc(3);
        chk("coin_sec0", 32'(tk_if.secunde), 0);
        cyc(1);
        chk("coin_first_tick", 32'(tk_if.sec_tick), 1);
        cyc(3);
        drive_load(5'd12, 6'd34);
        chk("coin_ore", 32'(tk_if.ore), 12);
        chk("coin_minute", 32'(tk_if.minute), 34);
        chk("coin_sec", 32'(tk_if.secunde), 0);
        chk("coin_no_tick", 32'(tk_if.sec_tick), 0);
        cyc(3);
        chk("coin_restart_wait", 32'(tk_if.sec_tick), 0);
        cyc(1);
        chk("coin_restart_tick", 32'(tk_if.sec_tick), 1);
        chk("coin_restart_sec", 32'(tk_if.secunde), 1);

        // Asynchronous reset mid-count, then load held through release.
        drive_load(5'd5, 6'd5);
        cyc(6);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        tk_if.ore_in    = 5'd3;
        tk_if.minute_in = 6'd4;
        tk_if.load      = 1'b1;
        cyc(2);
        chk("rst_hold_valid", 32'(tk_if.valid), 0);
        reset = 1'b1;
        cyc(1);
        chk("rel_ore", 32'(tk_if.ore), 3);
        chk("rel_minute", 32'(tk_if.minute), 4);
        chk("rel_valid", 32'(tk_if.valid), 1);
        tk_if.load = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
